// File: rtl/mem_cmd_pkg.sv
// Shared mem_cmd bus widths, error read data and responder FSM encoding.
// Imported by the responder top and its RAM sub-module.
package mem_cmd_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_RD_WAIT
  } state_e;

endpackage

// File: rtl/mem_cmd_ram_bytewise.sv
// Single-port DEPTH x 32 RAM, per-byte write enables, registered read.
// Array contents are never reset; only the read register is.
module mem_cmd_ram_bytewise
  import mem_cmd_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // q only moves on a read, so it holds the latched word while the FSM waits
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (rd_en) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_cmd_ram_responder.sv
// mem_cmd/mem_rsp responder backed by a word RAM with write waits and read latency.
// Define MEM_CMD_RAM_ADDR_CHECK_EN to trap out-of-range accesses via bus_err.
module mem_cmd_ram_responder
  import mem_cmd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                DEPTH      = 1024,
  parameter int                RD_LATENCY = 1,
  parameter int                WR_WAIT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_cmd_valid,
  output logic              mem_cmd_ready,
  input  logic              mem_cmd_instr,
  input  logic              mem_cmd_wr,
  input  logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic [BE_W-1:0]   mem_cmd_be,
  output logic              mem_rsp_ready,
  output logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              bus_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] RD_CNT0 = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT0 = 4'(WR_WAIT - 1);

  state_e            state;
  logic [3:0]        cnt;
  logic              rd_err;
  logic [ADDR_W-1:0] off;
  logic [AW-1:0]     idx;
  logic              in_range;
  logic              accept;
  logic              rd_go;
  logic              wr_go;
  logic [DATA_W-1:0] ram_q;
  logic              unused_ok;

  assign off = mem_cmd_addr - BASE_ADDR;
  assign idx = off[2 +: AW];

`ifdef MEM_CMD_RAM_ADDR_CHECK_EN
  assign in_range = (off[ADDR_W-1:AW+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  assign unused_ok = ^{mem_cmd_instr, off[1:0], off[ADDR_W-1:AW+2]};

  always_comb begin
    mem_cmd_ready = 1'b0;
    unique case (state)
      ST_IDLE:    mem_cmd_ready = mem_cmd_valid &&
                                  (!mem_cmd_wr || WR_WAIT == 0);
      ST_WR_WAIT: mem_cmd_ready = mem_cmd_valid && cnt == 4'd0;
      default:    mem_cmd_ready = 1'b0;
    endcase
  end

  assign accept = mem_cmd_valid && mem_cmd_ready;
  assign rd_go  = accept && !mem_cmd_wr;
  assign wr_go  = accept && mem_cmd_wr && in_range;

  mem_cmd_ram_bytewise #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (rd_go),
    .wr_en (wr_go),
    .be    (mem_cmd_be),
    .addr  (idx),
    .wdata (mem_cmd_wdata),
    .q     (ram_q)
  );

  // rsp is raised one edge early so it lands in the cnt==0 RD_WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mem_rsp_ready <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      mem_rsp_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rd_go) begin
            state         <= ST_RD_WAIT;
            cnt           <= RD_CNT0;
            mem_rsp_ready <= (RD_LATENCY == 1);
            rd_err        <= !in_range;
          end else if (mem_cmd_valid && mem_cmd_wr && WR_WAIT != 0) begin
            state <= ST_WR_WAIT;
            cnt   <= WR_CNT0;
          end
        end
        ST_WR_WAIT: begin
          if (!mem_cmd_valid || cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RD_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt           <= cnt - 4'd1;
            mem_rsp_ready <= (cnt == 4'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_rsp_rdata = rd_err ? ERR_RDATA : ram_q;

`ifdef MEM_CMD_RAM_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule
